// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// load/store traffic. One transaction in flight at a time; data has priority
// over fetch, except when data has been granted MAX_STREAK times in a row
// while a fetch was waiting.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1     = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic       LAT_GT1    = (LATENCY > 1) ? 1'b1 : 1'b0;

    state_t              state_r, state_s;
    logic [3:0]          wcnt_r, wcnt_s;
    logic [3:0]          streak_r, streak_s;
    logic                owner_data_r, owner_data_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic                mem_we_r, mem_we_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                mem_en_r, fetch_valid_r, data_valid_r, busy_r;
    logic                grant_data_s;

    // Data wins unless the streak limit is reached with a fetch waiting.
    always_comb begin
        grant_data_s = data_req && !((streak_r == STREAK_MAX) && fetch_req);
    end

    // Next-state, counters, owner and memory-side request capture.
    always_comb begin
        state_s      = state_r;
        wcnt_s       = wcnt_r;
        streak_s     = streak_r;
        owner_data_s = owner_data_r;
        mem_addr_s   = mem_addr_r;
        mem_we_s     = mem_we_r;
        mem_wdata_s  = mem_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req || data_req) begin
                    state_s      = ST_ISSUE;
                    owner_data_s = grant_data_s;
                    if (grant_data_s) begin
                        mem_addr_s  = data_addr;
                        mem_we_s    = data_we;
                        mem_wdata_s = data_wdata;
                        if (fetch_req) begin
                            streak_s = (streak_r < STREAK_MAX) ? (streak_r + 4'd1) : STREAK_MAX;
                        end else begin
                            streak_s = 4'd0;
                        end
                    end else begin
                        mem_addr_s  = fetch_addr;
                        mem_we_s    = 1'b0;
                        mem_wdata_s = {DATA_W{1'b0}};
                        streak_s    = 4'd0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wcnt_s = LAT_M1;
                if (LAT_GT1) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_WAIT: begin
                wcnt_s = wcnt_r - 4'd1;
                if (wcnt_r <= 4'd1) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, captured request and decoded outputs, all registered.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_r       <= ST_IDLE;
            wcnt_r        <= 4'd0;
            streak_r      <= 4'd0;
            owner_data_r  <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_we_r      <= 1'b0;
            mem_wdata_r   <= {DATA_W{1'b0}};
            mem_en_r      <= 1'b0;
            fetch_valid_r <= 1'b0;
            data_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            wcnt_r        <= wcnt_s;
            streak_r      <= streak_s;
            owner_data_r  <= owner_data_s;
            mem_addr_r    <= mem_addr_s;
            mem_we_r      <= mem_we_s;
            mem_wdata_r   <= mem_wdata_s;
            mem_en_r      <= (state_s == ST_ISSUE);
            fetch_valid_r <= (state_s == ST_DONE) && !owner_data_s;
            data_valid_r  <= (state_s == ST_DONE) && owner_data_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    // Read data passes straight from memory to the owner in its valid cycle.
    always_comb begin
        if (fetch_valid_r) begin
            fetch_data = mem_rdata;
        end else begin
            fetch_data = {DATA_W{1'b0}};
        end
        if (data_valid_r) begin
            data_rdata = mem_rdata;
        end else begin
            data_rdata = {DATA_W{1'b0}};
        end
    end

    assign mem_en      = mem_en_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign fetch_valid = fetch_valid_r;
    assign data_valid  = data_valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=2/MAX_STREAK=2 for
// the main scenarios, a second at LATENCY=1 for back-to-back fetch timing.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        _reset;
    logic        fetch_req, data_req, data_we;
    logic [31:0] fetch_addr, data_addr, data_wdata;
    logic [31:0] fetch_data, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        fetch_valid, data_valid, mem_en, mem_we, busy;

    logic        fetch_req1;
    logic [31:0] fetch_addr1;
    logic [31:0] fetch_data1, data_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        fetch_valid1, data_valid1, mem_en1, mem_we1, busy1;

    int check_count = 0;
    int error_count = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .MAX_STREAK(2)) dut (
        .clk(clk), ._reset(_reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_valid(data_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .MAX_STREAK(4)) dut1 (
        .clk(clk), ._reset(_reset),
        .fetch_req(fetch_req1), .fetch_addr(fetch_addr1), .fetch_data(fetch_data1), .fetch_valid(fetch_valid1),
        .data_req(1'b0), .data_we(1'b0), .data_addr(32'h0), .data_wdata(32'h0),
        .data_rdata(data_rdata1), .data_valid(data_valid1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    // Memory models: data appears exactly LATENCY cycles after mem_en.
    logic        p0 = 1'b0, p1 = 1'b0, q0 = 1'b0;
    logic [31:0] d0 = 32'h0, d1 = 32'h0, e0 = 32'h0;
    always @(posedge clk) begin
        p0 <= mem_en;  d0 <= mem_fn(mem_addr);
        p1 <= p0;      d1 <= d0;
        q0 <= mem_en1; e0 <= mem_fn(mem_addr1);
    end
    assign mem_rdata  = p1 ? d1 : 32'h0;
    assign mem_rdata1 = q0 ? e0 : 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctrl"}, {59'd0, mem_en, mem_we, fetch_valid, data_valid, busy}, 64'd0);
        check_eq({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
        check_eq({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    endtask

    // Requesters must hold req until their valid cycle.
    logic f_pend = 1'b0, d_pend = 1'b0;
    always @(posedge clk) begin
        if (!_reset) begin
            f_pend <= 1'b0;
            d_pend <= 1'b0;
        end else begin
            if (f_pend && !fetch_req && !fetch_valid) check_eq("fetch_req_dropped", 64'd0, 64'd1);
            if (d_pend && !data_req && !data_valid) check_eq("data_req_dropped", 64'd0, 64'd1);
            f_pend <= fetch_req;
            d_pend <= data_req;
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [5:0] grants;
    int         n_grants;
    logic [3:0] max_streak;

    initial begin
        _reset = 1'b0;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        fetch_req1 = 1'b0; fetch_addr1 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Single fetch
        _reset = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h40;
        check_eq("f_c0_busy", {63'd0, busy}, 64'd0);
        step();
        check_eq("f_c1_issue", {30'd0, mem_en, mem_we, mem_addr}, {30'd0, 1'b1, 1'b0, 32'h40});
        check_eq("f_c1_busy", {63'd0, busy}, 64'd1);
        step();
        check_eq("f_c2_quiet", {62'd0, mem_en, fetch_valid}, 64'd0);
        step();
        check_eq("f_c3_valid", {62'd0, fetch_valid, data_valid}, {62'd0, 2'b10});
        check_eq("f_c3_data", {32'd0, fetch_data}, {32'd0, 32'hDEAD_BEEF});
        fetch_req = 1'b0;
        step();
        check_eq("f_c4_idle", {62'd0, busy, fetch_valid}, 64'd0);

        // Store
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h100; data_wdata = 32'h1234_5678;
        step();
        check_eq("s_c1_ctrl", {62'd0, mem_en, mem_we}, {62'd0, 2'b11});
        check_eq("s_c1_addr", {32'd0, mem_addr}, {32'd0, 32'h100});
        check_eq("s_c1_wdata", {32'd0, mem_wdata}, {32'd0, 32'h1234_5678});
        step();
        check_eq("s_c2_valid", {63'd0, data_valid}, 64'd0);
        step();
        check_eq("s_c3_valid", {62'd0, data_valid, fetch_valid}, {62'd0, 2'b10});
        data_req = 1'b0; data_we = 1'b0;
        step();
        check_eq("s_c4_single", {62'd0, data_valid, busy}, 64'd0);

        // Contention: data load first, fetch right after
        fetch_req = 1'b1; fetch_addr = 32'h80;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200;
        step();
        check_eq("c_c1_issue", {30'd0, mem_en, mem_we, mem_addr}, {30'd0, 1'b1, 1'b0, 32'h200});
        step();
        step();
        check_eq("c_c3_valid", {62'd0, data_valid, fetch_valid}, {62'd0, 2'b10});
        check_eq("c_c3_rdata", {32'd0, data_rdata}, {32'd0, 32'hA5A5_585A});
        data_req = 1'b0;
        step();
        check_eq("c_c4_idle", {62'd0, mem_en, busy}, 64'd0);
        step();
        check_eq("c_c5_issue", {31'd0, mem_en, mem_addr}, {31'd0, 1'b1, 32'h80});
        step();
        step();
        check_eq("c_c7_valid", {62'd0, fetch_valid, data_valid}, {62'd0, 2'b10});
        check_eq("c_c7_fdata", {32'd0, fetch_data}, {32'd0, 32'hA5A5_5ADA});
        fetch_req = 1'b0;
        step();

        // Starvation limit (MAX_STREAK=2): expect d,d,f,d,d,f (bit=1 means data)
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
        fetch_req = 1'b1; fetch_addr = 32'h84;
        grants = 6'd0; n_grants = 0; max_streak = 4'd0;
        for (int c = 0; c < 60 && n_grants < 6; c++) begin
            step();
            if (dut.streak_r > max_streak) max_streak = dut.streak_r;
            if (mem_en) begin
                grants[n_grants] = (mem_addr == 32'h300);
                n_grants++;
            end
        end
        check_eq("starve_count", 64'(n_grants), 64'd6);
        check_eq("starve_order", {58'd0, grants}, {58'd0, 6'b011011});
        check_eq("starve_streak_le2", {63'd0, (max_streak > 4'd2)}, 64'd0);

        // Reset while an access is being issued
        _reset = 1'b0; data_req = 1'b0; fetch_req = 1'b0;
        #1;
        check_reset_outputs("rst_issue");
        step();
        step();
        _reset = 1'b1;

        // Reset during WAIT of a fetch, request kept high across it
        fetch_req = 1'b1; fetch_addr = 32'h44;
        step();
        check_eq("r_c1_issue", {31'd0, mem_en, mem_addr}, {31'd0, 1'b1, 32'h44});
        step();
        _reset = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        step();
        check_eq("r_hold1_novalid", {63'd0, fetch_valid}, 64'd0);
        step();
        check_eq("r_hold2_novalid", {63'd0, fetch_valid}, 64'd0);
        _reset = 1'b1;
        check_eq("r_rel_quiet", {62'd0, mem_en, busy}, 64'd0);
        step();
        check_eq("r_rel_issue", {31'd0, mem_en, mem_addr}, {31'd0, 1'b1, 32'h44});
        step();
        check_eq("r_rel_c2", {63'd0, fetch_valid}, 64'd0);
        step();
        check_eq("r_rel_valid", {63'd0, fetch_valid}, 64'd1);
        check_eq("r_rel_data", {32'd0, fetch_data}, {32'd0, 32'hA5A5_5A1E});
        fetch_req = 1'b0;
        step();

        // LATENCY=1 back-to-back fetches
        fetch_req1 = 1'b1; fetch_addr1 = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            step();
            check_eq($sformatf("l1_c%0d_en", c), {63'd0, mem_en1}, {63'd0, (c == 1 || c == 4 || c == 7)});
            check_eq($sformatf("l1_c%0d_valid", c), {62'd0, fetch_valid1, data_valid1}, {62'd0, (c % 3 == 2), 1'b0});
            if (c == 2) check_eq("l1_c2_data", {32'd0, fetch_data1}, {32'd0, 32'hA5A5_5A4A});
            if (c == 8) fetch_req1 = 1'b0;
        end
        step();
        check_eq("l1_idle", {63'd0, busy1}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
